// File: rtl/uart_script_player.sv
// Plays a stored script of bytes to a UART, one tx_req per entry, optionally looping.
// Latency: tx_req one cycle after start or tx_ready; backpressure by holding in WAIT until tx_ready.
module uart_script_player #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5,
    parameter int LOOP_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] last_index,
    input  logic                  start,
    input  logic                  repeat_en,
    input  logic                  abort,
    output logic                  tx_req,
    output logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_ready,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] index,
    output logic [LOOP_WIDTH-1:0] loops
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_last;
    logic [ADDR_WIDTH-1:0] r_index;
    logic [LOOP_WIDTH-1:0] r_loops;
    logic [DATA_WIDTH-1:0] r_tx_data;
    logic                  r_tx_req;
    logic                  r_busy;
    logic                  r_done;

    logic [ADDR_WIDTH-1:0] w_next_index;
    logic [LOOP_WIDTH-1:0] w_next_loops;

    assign w_next_index = ADDR_WIDTH'(r_index + 1'b1);
    assign w_next_loops = LOOP_WIDTH'(r_loops + 1'b1);

    // Script storage is never reset; reads in the FSM see the pre-write value.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_last    <= '0;
            r_index   <= '0;
            r_loops   <= '0;
            r_tx_data <= '0;
            r_tx_req  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_tx_req <= 1'b0;
            r_done   <= 1'b0;
            if (abort) begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (start) begin
                            r_last    <= last_index;
                            r_index   <= '0;
                            r_loops   <= '0;
                            r_tx_data <= r_mem[0];
                            r_tx_req  <= 1'b1;
                            r_busy    <= 1'b1;
                            r_state   <= REQ;
                        end
                    end
                    REQ: begin
                        r_state <= WAIT;
                    end
                    WAIT: begin
                        if (tx_ready) begin
                            if (r_index != r_last) begin
                                r_index   <= w_next_index;
                                r_tx_data <= r_mem[w_next_index];
                                r_tx_req  <= 1'b1;
                                r_state   <= REQ;
                            end else if (repeat_en) begin
                                r_index   <= '0;
                                r_loops   <= w_next_loops;
                                r_tx_data <= r_mem[0];
                                r_tx_req  <= 1'b1;
                                r_state   <= REQ;
                            end else begin
                                r_done  <= 1'b1;
                                r_busy  <= 1'b0;
                                r_state <= IDLE;
                            end
                        end
                    end
                    default: begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign tx_req  = r_tx_req;
    assign tx_data = r_tx_data;
    assign busy    = r_busy;
    assign done    = r_done;
    assign index   = r_index;
    assign loops   = r_loops;

endmodule

// File: tb/tb_uart_script_player.sv
// Randomised scoreboard bench for uart_script_player: expected byte stream is
// generated from a script array, checked by an independent tx_req monitor.
module tb_uart_script_player;

    localparam int DW = 8;
    localparam int AW = 5;
    localparam int LW = 16;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [AW-1:0] last_index = '0;
    logic          start = 1'b0;
    logic          repeat_en = 1'b0;
    logic          uart_abort = 1'b0;
    logic          uart_rdy = 1'b0;
    logic          stim_rdy = 1'b0;
    logic          tx_ready;
    logic          tx_req;
    logic [DW-1:0] tx_data;
    logic          busy;
    logic          done;
    logic [AW-1:0] index;
    logic [LW-1:0] loops;

    assign tx_ready = uart_rdy | stim_rdy;

    uart_script_player #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LOOP_WIDTH(LW)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .last_index(last_index), .start(start), .repeat_en(repeat_en), .abort(uart_abort),
        .tx_req(tx_req), .tx_data(tx_data), .tx_ready(tx_ready), .busy(busy), .done(done),
        .index(index), .loops(loops)
    );

    // Narrow-counter instance used to exercise loop-counter wrap in few cycles.
    logic       w2_wr_en = 1'b0;
    logic       w2_start = 1'b0;
    logic       w2_rep = 1'b0;
    logic       w2_rdy = 1'b0;
    logic       w2_req;
    logic [7:0] w2_data;
    logic       w2_busy;
    logic       w2_done;
    logic [1:0] w2_index;
    logic [3:0] w2_loops;

    uart_script_player #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .LOOP_WIDTH(4)) dut_wrap (
        .clk(clk), .reset(reset), .wr_en(w2_wr_en), .wr_addr(2'd0), .wr_data(8'hA5),
        .last_index(2'd0), .start(w2_start), .repeat_en(w2_rep), .abort(1'b0),
        .tx_req(w2_req), .tx_data(w2_data), .tx_ready(w2_rdy), .busy(w2_busy), .done(w2_done),
        .index(w2_index), .loops(w2_loops)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        int            idx;
        int            lp;
        bit            first;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] mem_model [DEPTH];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            n_tx = 0;
    int            done_cnt = 0;
    int            rdy_cyc = 0;
    int            mon_last_idx = -1;
    bit            abort_arm = 1'b0;
    int            w2_k = 0;
    int            w2_done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every tx_req and accounts done pulses.
    initial begin
        exp_t e;
        logic prev_req;
        prev_req = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_req) begin
                chk("req_single_cycle", prev_req, 0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_tx_req: got data 0x%0h index %0d expected none", tx_data, index);
                end else begin
                    e = exp_q.pop_front();
                    chk("tx_data", tx_data, e.d);
                    chk("tx_index", index, e.idx);
                    chk("tx_loops", loops, e.lp);
                    if (!e.first) chk("ready_to_req_latency", cyc - rdy_cyc, 1);
                    mon_last_idx = e.idx;
                    n_tx++;
                end
            end
            if (done) begin
                done_cnt++;
                chk("done_after_last_byte", exp_q.size(), 0);
            end
            prev_req = tx_req;
        end
    end

    // UART model: random completion delay, occasional spurious tx_ready while in REQ.
    initial begin
        int d;
        forever begin
            @(negedge clk);
            uart_rdy = 1'b0;
            uart_abort = 1'b0;
            if (tx_req) begin
                uart_rdy = ($urandom_range(0, 3) == 0);
                d = $urandom_range(1, 4);
                repeat (d - 1) begin
                    @(negedge clk);
                    uart_rdy = 1'b0;
                end
                @(negedge clk);
                uart_rdy = 1'b1;
                rdy_cyc = cyc;
                if (abort_arm && mon_last_idx == 1) begin
                    uart_abort = 1'b1;
                    abort_arm = 1'b0;
                end
            end
        end
    end

    // Wrap-instance UART: completes every byte on the cycle after its request.
    initial begin
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            w2_rdy = prev;
            prev = w2_req;
            if (w2_req) begin
                chk("wrap_loops", w2_loops, w2_k % 16);
                chk("wrap_data", w2_data, 8'hA5);
                w2_k++;
            end
            if (w2_done) w2_done_cnt++;
        end
    end

    task automatic wr(input int a, input logic [DW-1:0] v);
        @(negedge clk);
        wr_en = 1'b1;
        wr_addr = AW'(a);
        wr_data = v;
        mem_model[a] = v;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic push_expect(input int last, input int passes);
        for (int p = 0; p < passes; p++)
            for (int i = 0; i <= last; i++)
                exp_q.push_back('{d: mem_model[i], idx: i, lp: p % (1 << LW), first: (p == 0 && i == 0)});
    endtask

    task automatic do_start(input int last, input bit rep);
        @(negedge clk);
        last_index = AW'(last);
        repeat_en = rep;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        last_index = AW'($urandom);
    endtask

    task automatic wait_ntx(input int target, input string nm);
        int t = 0;
        while (n_tx < target && t < 4000) begin
            @(negedge clk);
            t++;
        end
        if (n_tx < target) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout, got %0d bytes expected %0d", nm, n_tx, target);
        end
    endtask

    task automatic wait_done(input int prev, input string nm);
        int t = 0;
        while (done_cnt == prev && t < 4000) begin
            @(negedge clk);
            t++;
        end
        repeat (4) @(negedge clk);
        chk(nm, done_cnt - prev, 1);
    endtask

    task automatic run_script(input int last, input int passes);
        int prev = done_cnt;
        int base = n_tx;
        push_expect(last, passes);
        do_start(last, passes > 1);
        // A second start while busy, with a different last_index, must be ignored.
        @(negedge clk);
        start = 1'b1;
        last_index = AW'($urandom);
        @(negedge clk);
        start = 1'b0;
        if (passes > 1) begin
            wait_ntx(base + (passes - 1) * (last + 1) + 1, "repeat_final_pass");
            repeat_en = 1'b0;
        end
        wait_done(prev, "done_count");
        chk("bytes_sent", n_tx - base, passes * (last + 1));
        chk("busy_after_done", busy, 0);
        chk("index_after_done", index, last);
        chk("loops_after_done", loops, passes - 1);
        chk("scoreboard_empty", exp_q.size(), 0);
    endtask

    initial begin
        int base;
        int prev;
        int t;
        int last;

        repeat (3) @(negedge clk);
        chk("rst_tx_req", tx_req, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_index", index, 0);
        chk("rst_loops", loops, 0);
        reset = 1'b0;

        wr(0, 8'hDE); wr(1, 8'hAD); wr(2, 8'hBE); wr(3, 8'hEF);
        run_script(3, 1);
        run_script(3, 3);

        wr(0, 8'h55);
        run_script(0, 1);

        // Spurious tx_ready while idle.
        @(negedge clk);
        stim_rdy = 1'b1;
        @(negedge clk);
        stim_rdy = 1'b0;
        chk("idle_spurious_busy", busy, 0);
        chk("idle_spurious_req", tx_req, 0);

        // Abort coincident with tx_ready at index 1.
        wr(0, 8'hDE);
        prev = done_cnt;
        base = n_tx;
        abort_arm = 1'b1;
        push_expect(3, 1);
        do_start(3, 1'b0);
        t = 0;
        while (abort_arm && t < 200) begin
            @(negedge clk);
            t++;
        end
        repeat (8) @(negedge clk);
        chk("abort_fired", abort_arm, 0);
        chk("abort_bytes", n_tx - base, 2);
        chk("abort_busy", busy, 0);
        chk("abort_index", index, 1);
        chk("abort_no_done", done_cnt - prev, 0);
        exp_q.delete();

        // Randomised scripts, including both last_index extremes.
        for (int it = 0; it < 6; it++) begin
            for (int a = 0; a < DEPTH; a++) wr(a, DW'($urandom));
            last = (it == 0) ? 0 : (it == 1) ? DEPTH - 1 : int'($urandom_range(0, DEPTH - 1));
            run_script(last, int'($urandom_range(1, 3)));
        end

        // Reset in the middle of the second pass of a repeating script.
        base = n_tx;
        push_expect(3, 3);
        do_start(3, 1'b1);
        wait_ntx(base + 6, "reset_mid_wait");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_tx_req", tx_req, 0);
        chk("midrst_tx_data", tx_data, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_index", index, 0);
        chk("midrst_loops", loops, 0);
        reset = 1'b0;
        repeat_en = 1'b0;
        base = n_tx;
        repeat (12) @(negedge clk);
        chk("midrst_no_more_req", n_tx - base, 0);
        exp_q.delete();

        // Loop counter wrap on the narrow instance.
        @(negedge clk);
        w2_wr_en = 1'b1;
        @(negedge clk);
        w2_wr_en = 1'b0;
        w2_rep = 1'b1;
        w2_start = 1'b1;
        @(negedge clk);
        w2_start = 1'b0;
        t = 0;
        while (w2_k < 20 && t < 500) begin
            @(negedge clk);
            t++;
        end
        w2_rep = 1'b0;
        repeat (6) @(negedge clk);
        chk("wrap_passes_reached", w2_k >= 20, 1);
        chk("wrap_done_count", w2_done_cnt, 1);
        chk("wrap_final_loops", w2_loops, (w2_k - 1) % 16);
        chk("wrap_busy", w2_busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
